// File: rtl/mem_lsu_if.sv
// Data-bus bundle between the memory stage (master) and the data memory fabric (slave).
// Request fields are held by the master until grant; rvalid carries read data or a write acknowledge.
interface mem_lsu_if #(
   parameter int ADDR_W = 32
) ();
   logic              dbus_req_o;
   logic              dbus_we_o;
   logic [3:0]        dbus_be_o;
   logic [ADDR_W-1:0] dbus_addr_o;
   logic [31:0]       dbus_wdata_o;
   logic              dbus_gnt_i;
   logic              dbus_rvalid_i;
   logic [31:0]       dbus_rdata_i;

   modport master (
      output dbus_req_o, dbus_we_o, dbus_be_o, dbus_addr_o, dbus_wdata_o,
      input  dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i
   );

   modport slave (
      input  dbus_req_o, dbus_we_o, dbus_be_o, dbus_addr_o, dbus_wdata_o,
      output dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i
   );
endinterface

// File: rtl/mem_lsu.sv
// Pipelined MEM stage: forwards EX/MEM fields to MEM/WB and runs loads/stores on a req/gnt/rvalid bus.
// Define MEM_LLSC_EN for the LL/SC link register; otherwise LL acts as LW and SC as an always-successful SW.
module mem_lsu #(
   parameter int ADDR_W     = 32,
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] wdata_i,
   input  logic        whilo_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   input  logic [3:0]  mem_op_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   output logic        stall_o,
   mem_lsu_if.master   dbus,
   output logic        valid_o,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        exc_adel_o,
   output logic        exc_ades_o,
   output logic [31:0] badvaddr_o
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;
   localparam logic [3:0] OP_LL  = 4'd9;
   localparam logic [3:0] OP_SC  = 4'd10;

   logic [1:0]        state;
   logic [3:0]        op_q;
   logic [1:0]        lane_q;
   logic [4:0]        p_wd;
   logic              p_wreg;
   logic [31:0]       p_wdata;
   logic              p_whilo;
   logic [31:0]       p_hi;
   logic [31:0]       p_lo;
   logic              req_q;
   logic              we_q;
   logic [3:0]        be_q;
   logic [ADDR_W-1:0] baddr_q;
   logic [31:0]       bwdata_q;

   logic        is_load, is_store, is_byte, is_half, is_word;
   logic        misal, mem_op, sc_fail, issue;
   logic [1:0]  lane;
   logic [3:0]  be;
   logic [31:0] st_data;
   logic [31:0] shifted, load_data;

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      is_byte  = 1'b0;
      is_half  = 1'b0;
      is_word  = 1'b0;
      case (mem_op_i)
         OP_LB, OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
         OP_LH, OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
         OP_LW, OP_LL:  begin is_load  = 1'b1; is_word = 1'b1; end
         OP_SB:         begin is_store = 1'b1; is_byte = 1'b1; end
         OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
         OP_SW, OP_SC:  begin is_store = 1'b1; is_word = 1'b1; end
         default: ;
      endcase
      mem_op = is_load | is_store;
      misal  = (is_half & mem_addr_i[0]) | (is_word & (|mem_addr_i[1:0]));
   end

`ifdef MEM_LLSC_EN
   logic        link_q;
   logic [29:0] link_addr_q;
   logic [29:0] word_q;
   assign sc_fail = (mem_op_i == OP_SC) & ~(link_q & (link_addr_q == mem_addr_i[31:2]));
`else
   assign sc_fail = 1'b0;
`endif

   assign issue   = mem_op & ~misal & ~sc_fail;
   assign stall_o = (state != S_IDLE) | (in_valid_i & issue);

   // Lane = byte offset of the access inside the 32-bit bus word; big-endian mirrors it.
   always_comb begin
      if (is_word)
         lane = 2'd0;
      else if (is_half)
         lane = BIG_ENDIAN ? {~mem_addr_i[1], 1'b0} : {mem_addr_i[1], 1'b0};
      else
         lane = BIG_ENDIAN ? ~mem_addr_i[1:0] : mem_addr_i[1:0];
      be      = (is_word ? 4'hF : (is_half ? 4'h3 : 4'h1)) << lane;
      st_data = is_byte ? {4{mem_wdata_i[7:0]}} :
                is_half ? {2{mem_wdata_i[15:0]}} : mem_wdata_i;
   end

   always_comb begin
      shifted = dbus.dbus_rdata_i >> {lane_q, 3'b000};
      case (op_q)
         OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
         OP_LBU:  load_data = {24'h0, shifted[7:0]};
         OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
         OP_LHU:  load_data = {16'h0, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         op_q       <= 4'd0;
         lane_q     <= 2'd0;
         p_wd       <= 5'd0;
         p_wreg     <= 1'b0;
         p_wdata    <= 32'd0;
         p_whilo    <= 1'b0;
         p_hi       <= 32'd0;
         p_lo       <= 32'd0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         be_q       <= 4'd0;
         baddr_q    <= '0;
         bwdata_q   <= 32'd0;
         valid_o    <= 1'b0;
         wd_o       <= 5'd0;
         wreg_o     <= 1'b0;
         wdata_o    <= 32'd0;
         whilo_o    <= 1'b0;
         hi_o       <= 32'd0;
         lo_o       <= 32'd0;
         exc_adel_o <= 1'b0;
         exc_ades_o <= 1'b0;
         badvaddr_o <= 32'd0;
`ifdef MEM_LLSC_EN
         link_q      <= 1'b0;
         link_addr_q <= 30'd0;
         word_q      <= 30'd0;
`endif
      end else begin
         valid_o    <= 1'b0;
         exc_adel_o <= 1'b0;
         exc_ades_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid_i && issue) begin
                  op_q     <= mem_op_i;
                  lane_q   <= lane;
                  p_wd     <= wd_i;
                  p_wreg   <= wreg_i;
                  p_wdata  <= wdata_i;
                  p_whilo  <= whilo_i;
                  p_hi     <= hi_i;
                  p_lo     <= lo_i;
                  req_q    <= 1'b1;
                  we_q     <= is_store;
                  be_q     <= be;
                  baddr_q  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                  bwdata_q <= st_data;
`ifdef MEM_LLSC_EN
                  word_q   <= mem_addr_i[31:2];
`endif
                  state    <= S_REQ;
               end else if (in_valid_i) begin
                  valid_o <= 1'b1;
                  wd_o    <= wd_i;
                  wreg_o  <= wreg_i;
                  wdata_o <= wdata_i;
                  whilo_o <= whilo_i;
                  hi_o    <= hi_i;
                  lo_o    <= lo_i;
                  if (mem_op && misal) begin
                     wreg_o     <= 1'b0;
                     exc_adel_o <= is_load;
                     exc_ades_o <= is_store;
                     badvaddr_o <= mem_addr_i;
                  end else if (mem_op) begin
                     // Failed SC: report 0 to the destination register without touching the bus.
                     wreg_o  <= 1'b1;
                     wdata_o <= 32'd0;
                  end
               end
            end
            S_REQ: begin
               if (dbus.dbus_gnt_i) begin
                  req_q <= 1'b0;
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (dbus.dbus_rvalid_i) begin
                  state   <= S_IDLE;
                  valid_o <= 1'b1;
                  wd_o    <= p_wd;
                  whilo_o <= p_whilo;
                  hi_o    <= p_hi;
                  lo_o    <= p_lo;
                  if (op_q == OP_SC) begin
                     wreg_o  <= 1'b1;
                     wdata_o <= 32'd1;
                  end else if (we_q) begin
                     wreg_o  <= 1'b0;
                     wdata_o <= p_wdata;
                  end else begin
                     wreg_o  <= p_wreg;
                     wdata_o <= load_data;
                  end
`ifdef MEM_LLSC_EN
                  if (op_q == OP_LL) begin
                     link_q      <= 1'b1;
                     link_addr_q <= word_q;
                  end else if (we_q && (word_q == link_addr_q)) begin
                     link_q <= 1'b0;
                  end
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign dbus.dbus_req_o   = req_q;
   assign dbus.dbus_we_o    = we_q;
   assign dbus.dbus_be_o    = be_q;
   assign dbus.dbus_addr_o  = baddr_q;
   assign dbus.dbus_wdata_o = bwdata_q;
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Pipelined memory-access stage for the MIPS core. It sits between EX/MEM and MEM/WB and replaces the pure pass-through MEM stage. Register, HI/LO and write-enable fields are carried forward through an output register. Loads and stores are issued on a req/gnt/rvalid data bus, with byte/half/word lane steering and sign/zero extension. Misaligned accesses raise an address exception, and the upstream pipeline stalls while an access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32: data-bus address width. Must be ≥ 3; only the low `ADDR_W` bits of `mem_addr_i` are driven.
- `BIG_ENDIAN`, 0: lane order. 0 = byte 0 on `[7:0]`; 1 = byte 0 on `[31:24]`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid_i`  in  1  EX/MEM holds a valid instruction.
- `wd_i`, `wreg_i`, `wdata_i`  in  5/1/32  GPR write destination, write enable and ALU result.
- `whilo_i`, `hi_i`, `lo_i`  in  1/32/32  HI/LO write enable and values.
- `mem_op_i`  in  4  access type:
  - 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC.
  - 11–15 are treated as NONE.
- `mem_addr_i`  in  32  effective address.
- `mem_wdata_i`  in  32  store data, right-aligned.
- `stall_o`  out  1  upstream must hold its inputs.
- `dbus_req_o`, `dbus_we_o`  out  1/1  bus request and write strobe.
- `dbus_be_o`  out  4  byte enables.
- `dbus_addr_o`  out  `ADDR_W`  word-aligned address (low 2 bits always 0).
- `dbus_wdata_o`  out  32  lane-replicated store data.
- `dbus_gnt_i`  in  1  request accepted.
- `dbus_rvalid_i`, `dbus_rdata_i`  in  1/32  response (read data, or write acknowledge).
- `valid_o`, `wd_o`, `wreg_o`, `wdata_o`, `whilo_o`, `hi_o`, `lo_o`  out  registered results toward WB.
- `exc_adel_o`, `exc_ades_o`  out  1/1  load or store address error, one-cycle pulse aligned with `valid_o`.
- `badvaddr_o`  out  32  faulting address.

## Operation
State machine: IDLE, REQ, WAIT.

- **IDLE:**
  - `in_valid_i` with NONE: latch the fields and present them on the outputs next cycle with `valid_o`=1. No bus activity.
  - Memory op, misaligned (half-word with addr[0]≠0; word, LL or SC with addr[1:0]≠0):
    - No bus activity.
    - Next cycle: `valid_o`=1, `wreg_o`=0, `exc_adel_o` (loads) or `exc_ades_o` (stores) = 1, `badvaddr_o`=addr.
  - Aligned memory op: latch everything and go to REQ.
- **REQ:**
  - `dbus_req_o`=1. `dbus_addr_o`, `dbus_we_o`, `dbus_be_o` and `dbus_wdata_o` stay stable until `dbus_gnt_i`.
  - On `dbus_gnt_i`, go to WAIT.
- **WAIT:**
  - `dbus_req_o`=0.
  - On `dbus_rvalid_i`:
    - Loads: extract the lane and extend (LB/LH sign-extend; LBU/LHU zero-extend; LW/LL take the full word) into `wdata_o`.
    - Stores: `wreg_o`=0, except SC (see Configuration).
    - Next cycle: `valid_o`=1. Return to IDLE.
- **Byte enables (little-endian):**
  - Byte access: `1<<addr[1:0]`.
  - Half-word access: `0011` or `1100`.
  - Word access: `1111`.
  - `BIG_ENDIAN`=1 mirrors the enables.
- **Store data:** SB replicates the byte ×4; SH replicates the half-word ×2.
- **`stall_o`:** `= (state!=IDLE) | (in_valid_i & aligned memory op)`.
- **Reset:**
  - Outputs: `valid_o`, `wreg_o`, `whilo_o`, `dbus_req_o`, `dbus_we_o`, `exc_*` = 0.
  - Buses: `wd_o`, `wdata_o`, `hi_o`, `lo_o`, `badvaddr_o`, `dbus_*` data and address = 0; `dbus_be_o`=0.
  - State: state=IDLE, link bit=0.
- **Reset mid-access:** `rst` asserted in REQ or WAIT aborts the access immediately. A `dbus_rvalid_i` that arrives later while in IDLE is ignored.

## Timing
- Pass-through (NONE): latency 1 cycle, no stall.
- Bus access: accept at cycle 0, `dbus_req_o` high from cycle 1.
- With `gnt` at cycle 1 and `rvalid` at cycle 2, `valid_o` is high at cycle 3; minimum load/store latency is 3 cycles.
- `gnt` and `rvalid` in the same cycle are not allowed. `rvalid` is only sampled in WAIT.
- `stall_o` deasserts combinationally in the cycle the state returns to IDLE. The next instruction is accepted in that cycle.

## Configuration
- `MEM_LLSC_EN` defined:
  - LL sets the link bit and latches the word address on completion.
  - SC with link=1 and a matching address performs the store. It then writes `wdata_o`=1 with `wreg_o`=1.
  - SC otherwise performs no bus access and writes `wdata_o`=0 with `wreg_o`=1, with 1-cycle latency.
  - Any other completed store to the linked word clears the link bit.
- `MEM_LLSC_EN` undefined: no link register. LL behaves as LW. SC behaves as SW and writes `wdata_o`=1 with `wreg_o`=1.

## Test plan
- NONE op, `wd_i`=3, `wdata_i`=0x1234 → next cycle `valid_o`=1, `wd_o`=3, `wdata_o`=0x1234, `stall_o`=0, no `dbus_req_o`.
- LB at addr 0x101 with rdata 0x0000_8000, little-endian → `dbus_be_o`=0010, `dbus_addr_o`=0x100, `wdata_o`=0xFFFF_FF80. LBU of the same → 0x0000_0080.
- SH at 0x202 with data 0xABCD → `dbus_be_o`=1100, `dbus_wdata_o`=0xABCD_ABCD, `wreg_o`=0.
- LW at 0x103 → no bus request; next cycle `exc_adel_o`=1, `badvaddr_o`=0x103, `wreg_o`=0.
- `gnt` delayed 4 cycles → request fields held stable and `stall_o`=1 throughout. `rst` asserted in WAIT → all outputs reset; a later `rvalid` is ignored.
- With `MEM_LLSC_EN`: LL 0x40, then SC 0x40 → store issued, `wdata_o`=1. LL 0x40, SW 0x40, SC 0x40 → SC issues no request, `wdata_o`=0.
